// File: rtl/axis_block_packer.sv
// axis_block_packer
//
// Packs a stream of IN_WIDTH-bit AXI-Stream words into DATA_WIDTH-bit blocks
// for the downstream block FIFO. WORDS = DATA_WIDTH/IN_WIDTH words form one
// block, with the first word in the MSBs. When tlast arrives before a block
// is full, the block is closed early. Its unfilled low slots are zero, and
// out_words tells the consumer how many slots are real. A block never mixes
// words from two messages.
//
// Ports:
//   clk               single clock, everything on posedge
//   reset             synchronous, active-high
//   s_axis_tdata      input word
//   s_axis_tvalid     input word valid
//   s_axis_tready     input word accepted when high together with tvalid
//   s_axis_tlast      last word of a message
//   fifo_wdata        packed block (registered)
//   fifo_write_tvalid block valid
//   fifo_write_tready FIFO can take the block
//   out_last          block holds the message's final word
//   out_words         number of valid words in the block (1..WORDS)
//
// DATA_WIDTH must be an integer multiple of IN_WIDTH.

module axis_block_packer #(
  parameter  int DATA_WIDTH = 128,
  parameter  int IN_WIDTH   = 32,
  localparam int WORDS      = DATA_WIDTH / IN_WIDTH,
  localparam int CNT_WIDTH  = $clog2(WORDS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_write_tvalid,
  input  logic                  fifo_write_tready,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  out_words
);

  logic [DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  out_last_reg, out_last_next;
  logic [CNT_WIDTH-1:0]  out_words_reg, out_words_next;

  // Accumulator with the incoming word dropped into slot cnt. Slots above cnt
  // are always zero because the accumulator is cleared on every completion
  // and filled strictly in order, so this is also the zero-padded block.
  logic [DATA_WIDTH-1:0] acc_ins;

  logic accept;
  logic complete;

  // Combinational from fifo_write_tready: a draining block frees the output
  // register in the same cycle, which is what keeps one word per cycle.
  assign s_axis_tready = !out_valid_reg || fifo_write_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept &&
                         (s_axis_tlast || (cnt_reg == CNT_WIDTH'(WORDS - 1)));

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slot
      assign acc_ins[DATA_WIDTH-1-gi*IN_WIDTH -: IN_WIDTH] =
        (cnt_reg == CNT_WIDTH'(gi)) ? s_axis_tdata
                                    : acc_reg[DATA_WIDTH-1-gi*IN_WIDTH -: IN_WIDTH];
    end
  endgenerate

  always_comb begin
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    out_words_next = out_words_reg;

    if (complete) begin
      // A completion always loads the output register; if the old block is
      // draining this same cycle, valid simply stays high.
      out_data_next  = acc_ins;
      out_valid_next = 1'b1;
      out_words_next = cnt_reg + CNT_WIDTH'(1);
      out_last_next  = s_axis_tlast;
      acc_next       = '0;
      cnt_next       = '0;
    end else begin
      if (accept) begin
        acc_next = acc_ins;
        cnt_next = cnt_reg + CNT_WIDTH'(1);
      end
      if (out_valid_reg && fifo_write_tready) begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_words_reg <= '0;
    end else begin
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      out_words_reg <= out_words_next;
    end
  end

  assign fifo_wdata        = out_data_reg;
  assign fifo_write_tvalid = out_valid_reg;
  assign out_last          = out_last_reg;
  assign out_words         = out_words_reg;

endmodule

// File: tb/tb_axis_block_packer.sv
// Testbench for axis_block_packer: directed cases followed by a randomized
// regression. Expected blocks are produced by chunking each message into
// groups of WORDS words and pushed into a queue when the message is issued.
// A separate monitor pops and compares every block the DUT hands over.

module tb_axis_block_packer;

  localparam int DW    = 128;
  localparam int IW    = 32;
  localparam int WORDS = DW / IW;
  localparam int CW    = $clog2(WORDS) + 1;
  localparam int N_MSG = 800;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_write_tvalid;
  logic          fifo_write_tready;
  logic          out_last;
  logic [CW-1:0] out_words;

  axis_block_packer #(.DATA_WIDTH(DW), .IN_WIDTH(IW)) dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .fifo_wdata       (fifo_wdata),
    .fifo_write_tvalid(fifo_write_tvalid),
    .fifo_write_tready(fifo_write_tready),
    .out_last         (out_last),
    .out_words        (out_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] words;
    logic          last;
  } blk_t;

  blk_t          exp_q[$];
  logic [IW-1:0] msg[$];
  int            checks = 0;
  int            errors = 0;
  int            blk_count = 0;
  bit            rand_valid = 1'b0;
  bit            rand_ready = 1'b0;
  bit            ready_force = 1'b1;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: split the message into WORDS-word groups, first word in
  // the MSBs, short tail zero-padded, last group flagged.
  task automatic push_msg();
    int   len;
    int   nb;
    blk_t e;
    len = msg.size();
    nb  = (len + WORDS - 1) / WORDS;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int k = 0; k < WORDS; k++) begin
        int idx;
        idx    = b * WORDS + k;
        e.data = {e.data[DW-IW-1:0], (idx < len) ? msg[idx] : {IW{1'b0}}};
      end
      e.words = CW'(((len - b * WORDS) < WORDS) ? (len - b * WORDS) : WORDS);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [IW-1:0] d, input logic l);
    int guard;
    guard        = 0;
    s_axis_tdata = d;
    s_axis_tlast = l;
    while (1) begin
      s_axis_tvalid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      guard++;
      if (guard > 2000) begin
        $display("FAIL send_timeout: got stalled expected accept");
        $fatal(1, "input never accepted");
      end
    end
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg.size(); i++) send_word(msg[i], i == msg.size() - 1);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || fifo_write_tvalid) && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_done", DW'(guard < 2000), DW'(1));
  endtask

  // FIFO-side ready driver: single writer of fifo_write_tready.
  initial begin
    fifo_write_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      fifo_write_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: samples on the falling edge, away from DUT updates.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [CW-1:0] prev_words;
    logic          prev_last;
    blk_t          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_words = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      check("s_tready_rule", DW'(s_axis_tready),
            DW'(!fifo_write_tvalid || fifo_write_tready));
      if (prev_stall) begin
        check("hold_valid", DW'(fifo_write_tvalid), DW'(1));
        check("hold_data",  fifo_wdata, prev_data);
        check("hold_words", DW'(out_words), DW'(prev_words));
        check("hold_last",  DW'(out_last), DW'(prev_last));
      end
      if (fifo_write_tvalid && fifo_write_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got %h expected none", fifo_wdata);
        end else begin
          e = exp_q.pop_front();
          blk_count++;
          $display("block %0d: data=%h words=%0d last=%0d", blk_count,
                   fifo_wdata, out_words, out_last);
          check("blk_data",  fifo_wdata, e.data);
          check("blk_words", DW'(out_words), DW'(e.words));
          check("blk_last",  DW'(out_last), DW'(e.last));
        end
      end
      prev_stall = fifo_write_tvalid && !fifo_write_tready;
      prev_data  = fifo_wdata;
      prev_words = out_words;
      prev_last  = out_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",  DW'(fifo_write_tvalid), DW'(0));
    check("rst_data",   fifo_wdata, DW'(0));
    check("rst_words",  DW'(out_words), DW'(0));
    check("rst_last",   DW'(out_last), DW'(0));
    check("rst_tready", DW'(s_axis_tready), DW'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_tready", DW'(s_axis_tready), DW'(1));
    @(posedge clk);
    #1;

    // Eight words, two full blocks, latency of one cycle.
    msg = {};
    for (int i = 1; i <= 8; i++) msg.push_back(IW'(i));
    push_msg();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) check("pre_complete_valid", DW'(fifo_write_tvalid), DW'(0));
      send_word(msg[i], i == 7);
      if (i == 3) check("complete_latency", DW'(fifo_write_tvalid), DW'(1));
    end
    wait_drain();

    // Short message then a one-word message.
    msg = {32'hAAAAAAAA, 32'hBBBBBBBB};
    push_msg();
    send_msg();
    msg = {32'hCCCCCCCC};
    push_msg();
    send_msg();
    wait_drain();

    // Back-pressure: stall the first block for five cycles.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    msg = {32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5};
    push_msg();
    for (int i = 0; i < 4; i++) send_word(msg[i], 1'b0);
    s_axis_tdata  = msg[4];
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_tready", DW'(s_axis_tready), DW'(0));
      check("stall_valid",  DW'(fifo_write_tvalid), DW'(1));
    end
    ready_force = 1'b1;
    @(negedge clk);
    check("release_tready", DW'(s_axis_tready), DW'(1));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    send_word(msg[5], 1'b1);
    wait_drain();

    // Reset mid-block discards the partial words.
    for (int i = 0; i < 3; i++) send_word(IW'(32'hEE0 + i), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid",  DW'(fifo_write_tvalid), DW'(0));
    check("midrst_tready", DW'(s_axis_tready), DW'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    msg = {32'h10, 32'h11, 32'h12, 32'h13};
    push_msg();
    send_msg();
    wait_drain();

    // Randomized regression.
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    for (int m = 0; m < N_MSG; m++) begin
      int len;
      len = $urandom_range(1, 40);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back($urandom());
      push_msg();
      send_msg();
    end
    rand_valid  = 1'b0;
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", DW'(exp_q.size()), DW'(0));
    check("final_idle", DW'(fifo_write_tvalid), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
